// File: rtl/tm1638_pkg.sv
// Shared constants, state types and frame helpers for the TM1638 display driver.
package tm1638_pkg;

    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON    = 8'h88;

    localparam int F0_BYTES = 1;
    localparam int F1_BYTES = 17;
    localparam int F2_BYTES = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_F0,
        ST_GAP,
        ST_F1,
        ST_F2
    } state_e;

    typedef enum logic [1:0] {
        PH_WAIT,
        PH_BYTES,
        PH_HOLD
    } phase_e;

    function automatic logic [4:0] frame_last_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 5'(F0_BYTES - 1);
            2'd1:    return 5'(F1_BYTES - 1);
            default: return 5'(F2_BYTES - 1);
        endcase
    endfunction

    function automatic state_e frame_state(input logic [1:0] idx);
        case (idx)
            2'd0:    return ST_F0;
            2'd1:    return ST_F1;
            default: return ST_F2;
        endcase
    endfunction

endpackage

// File: rtl/tm1638_byte_tx.sv
// LSB-first byte serialiser: each bit is H cycles of tm_clk low then H cycles high.
// ready also rises in the final cycle of a byte so bytes can run back to back.
module tm1638_byte_tx #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rel,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx_clk,
    output logic       tx_dio
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    logic       active_q, active_d;
    logic       high_q, high_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       clk_q, clk_d;
    logic       dio_q, dio_d;

    assign ready  = !active_q || (high_q && (bit_q == 3'd7) && (cnt_q == HALF_LAST));
    assign tx_clk = clk_q;
    assign tx_dio = dio_q;

    always_comb begin
        active_d = active_q;
        high_d   = high_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        clk_d    = clk_q;
        dio_d    = dio_q;
        if (start && ready) begin
            active_d = 1'b1;
            high_d   = 1'b0;
            bit_d    = 3'd0;
            cnt_d    = 8'd0;
            shreg_d  = data;
            clk_d    = 1'b0;
            dio_d    = data[0];
        end else if (active_q) begin
            if (cnt_q == HALF_LAST) begin
                cnt_d = 8'd0;
                if (!high_q) begin
                    high_d = 1'b1;
                    clk_d  = 1'b1;
                end else if (bit_q != 3'd7) begin
                    // Data only moves together with the falling clock.
                    bit_d   = bit_q + 3'd1;
                    high_d  = 1'b0;
                    clk_d   = 1'b0;
                    shreg_d = shreg_q >> 1;
                    dio_d   = shreg_q[1];
                end else begin
                    active_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (rel) begin
            dio_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            high_q   <= 1'b0;
            bit_q    <= 3'd0;
            cnt_q    <= 8'd0;
            shreg_q  <= 8'd0;
            clk_q    <= 1'b1;
            dio_q    <= 1'b1;
        end else begin
            active_q <= active_d;
            high_q   <= high_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            clk_q    <= clk_d;
            dio_q    <= dio_d;
        end
    end

endmodule

// File: rtl/tm1638_driver.sv
// TM1638 refresh sequencer: sends the auto-increment, data and display-on frames
// from shadow copies of the inputs captured when a refresh is accepted.
module tm1638_driver
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic [63:0] disp_data,
    input  logic [7:0]  led,
    input  logic [2:0]  brightness,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0] H_LAST   = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [1:0]  frame_q, frame_d;
    logic [4:0]  byte_q, byte_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        stb_q, stb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] disp_q, disp_d;
    logic [7:0]  led_q, led_d;
    logic [2:0]  bri_q, bri_d;

    logic        tx_start, tx_rel, tx_ready;
    logic [4:0]  tx_idx;
    logic [7:0]  tx_byte;
    logic [3:0]  dat_j;
    logic [2:0]  dat_k;

    tm1638_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte_tx (
        .clk    (clk),
        .rst    (rst),
        .start  (tx_start),
        .rel    (tx_rel),
        .data   (tx_byte),
        .ready  (tx_ready),
        .tx_clk (tm_clk),
        .tx_dio (tm_dio)
    );

    assign tm_stb = stb_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // Data bytes alternate digit segment byte and LED byte for each position.
    always_comb begin
        dat_j   = tx_idx[3:0] - 4'd1;
        dat_k   = dat_j[3:1];
        tx_byte = CMD_ADDR0;
        case (frame_q)
            2'd0: tx_byte = CMD_WRITE_AUTO;
            2'd1: begin
                if (tx_idx == 5'd0)
                    tx_byte = CMD_ADDR0;
                else if (!dat_j[0])
                    tx_byte = disp_q[{dat_k, 3'b000} +: 8];
                else
                    tx_byte = {7'b0, led_q[dat_k]};
            end
            default: tx_byte = CMD_DISP_ON | {5'b0, bri_q};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        frame_d  = frame_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        stb_d    = stb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        disp_d   = disp_q;
        led_d    = led_q;
        bri_d    = bri_q;
        tx_start = 1'b0;
        tx_rel   = 1'b0;
        tx_idx   = 5'd0;
        case (state_q)
            ST_IDLE: begin
                if (update) begin
                    disp_d  = disp_data;
                    led_d   = led;
                    bri_d   = brightness;
                    state_d = ST_F0;
                    phase_d = PH_WAIT;
                    frame_d = 2'd0;
                    cnt_d   = 9'd0;
                    stb_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_F0, ST_F1, ST_F2: begin
                case (phase_q)
                    PH_WAIT: begin
                        if (cnt_q == H_LAST) begin
                            tx_start = 1'b1;
                            tx_idx   = 5'd0;
                            byte_d   = 5'd0;
                            phase_d  = PH_BYTES;
                            cnt_d    = 9'd0;
                        end else begin
                            cnt_d = cnt_q + 9'd1;
                        end
                    end
                    PH_BYTES: begin
                        if (tx_ready) begin
                            if (byte_q == frame_last_byte(frame_q)) begin
                                phase_d = PH_HOLD;
                                cnt_d   = 9'd0;
                            end else begin
                                tx_start = 1'b1;
                                tx_idx   = byte_q + 5'd1;
                                byte_d   = byte_q + 5'd1;
                            end
                        end
                    end
                    default: begin
                        if (cnt_q == H_LAST) begin
                            stb_d   = 1'b1;
                            tx_rel  = 1'b1;
                            state_d = ST_GAP;
                            cnt_d   = 9'd0;
                        end else begin
                            cnt_d = cnt_q + 9'd1;
                        end
                    end
                endcase
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 9'd0;
                    if (frame_q == 2'd2) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        frame_d = frame_q + 2'd1;
                        state_d = frame_state(frame_q + 2'd1);
                        phase_d = PH_WAIT;
                        stb_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_WAIT;
            frame_q <= 2'd0;
            byte_q  <= 5'd0;
            cnt_q   <= 9'd0;
            stb_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= 64'd0;
            led_q   <= 8'd0;
            bri_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            frame_q <= frame_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
            led_q   <= led_d;
            bri_q   <= bri_d;
        end
    end

endmodule
